// File: rtl/arb4_pkg.sv
// Shared constants and FSM state type for the 4-way round-robin arbiter.
package arb4_pkg;

    localparam int NREQ = 4;
    localparam int IDXW = $clog2(NREQ);
    localparam int CNTW = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

endpackage

// File: rtl/rr_pick4.sv
// Combinational round-robin picker: first set request searching upward from PTR+1 (mod 4).
module rr_pick4
    import arb4_pkg::*;
(
    input  logic [NREQ-1:0] REQ,
    input  logic [IDXW-1:0] PTR,
    output logic [NREQ-1:0] ONEHOT,
    output logic [IDXW-1:0] IDX,
    output logic            VALID
);

    logic [IDXW-1:0] cand;

    always_comb begin
        ONEHOT = '0;
        IDX    = '0;
        VALID  = 1'b0;
        cand   = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            // index wraps naturally in IDXW bits
            cand = IDXW'(32'(PTR) + i + 32'd1);
            if (!VALID && REQ[cand]) begin
                VALID        = 1'b1;
                IDX          = cand;
                ONEHOT[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/arb4_rr.sv
// 4-requester round-robin arbiter with registered one-hot grant.
// Optional forced release after HOLD_MAX grant cycles when ARB4_TIMEOUT_EN is defined.
module arb4_rr
    import arb4_pkg::*;
#(
    parameter int HOLD_MAX = 15
) (
    input  logic            CK,
    input  logic            CDN,
    input  logic [NREQ-1:0] REQ,
    input  logic            DONE,
    output logic [NREQ-1:0] GNT,
    output logic [IDXW-1:0] GID,
    output logic            BUSY,
    output logic            TOUT
);

    state_t          state;
    logic [IDXW-1:0] ptr;
    logic [NREQ-1:0] pick_oh;
    logic [IDXW-1:0] pick_idx;
    logic            pick_valid;
    logic            rel;

    rr_pick4 u_pick (
        .REQ    (REQ),
        .PTR    (ptr),
        .ONEHOT (pick_oh),
        .IDX    (pick_idx),
        .VALID  (pick_valid)
    );

    assign rel = DONE || !REQ[GID];

`ifdef ARB4_TIMEOUT_EN
    localparam logic [CNTW-1:0] HOLD_LAST = CNTW'(HOLD_MAX - 1);
    logic [CNTW-1:0] cnt;
    logic            expire;

    assign expire = (cnt == HOLD_LAST);
`else
    assign TOUT = 1'b0;
`endif

    always_ff @(posedge CK or negedge CDN) begin
        if (!CDN) begin
            state <= IDLE;
            GNT   <= '0;
            GID   <= '0;
            BUSY  <= 1'b0;
            ptr   <= '1;
`ifdef ARB4_TIMEOUT_EN
            cnt   <= '0;
            TOUT  <= 1'b0;
`endif
        end else begin
`ifdef ARB4_TIMEOUT_EN
            TOUT <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        GNT   <= pick_oh;
                        GID   <= pick_idx;
                        BUSY  <= 1'b1;
                        state <= GRANT;
`ifdef ARB4_TIMEOUT_EN
                        cnt   <= '0;
`endif
                    end
                end
                GRANT: begin
                    if (rel) begin
                        GNT   <= '0;
                        BUSY  <= 1'b0;
                        ptr   <= GID;
                        state <= IDLE;
                    end
`ifdef ARB4_TIMEOUT_EN
                    // a normal release on the same edge takes precedence, so no TOUT then
                    else if (expire) begin
                        GNT   <= '0;
                        BUSY  <= 1'b0;
                        ptr   <= GID;
                        state <= IDLE;
                        TOUT  <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_arb4_rr.sv
// Scoreboard bench for arb4_rr: stimulus queues expected outputs, a negedge monitor compares.
module tb_arb4_rr;

    logic       CK   = 1'b0;
    logic       CDN  = 1'b1;
    logic [3:0] REQ  = 4'b0000;
    logic       DONE = 1'b0;
    logic [3:0] GNT;
    logic [1:0] GID;
    logic       BUSY;
    logic       TOUT;

    typedef struct {
        int       cyc;
        logic [3:0] gnt;
        logic [1:0] gid;
        logic       tout;
    } exp_t;

    exp_t q[$];
    exp_t me;
    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;

    arb4_rr #(.HOLD_MAX(15)) dut (
        .CK   (CK),
        .CDN  (CDN),
        .REQ  (REQ),
        .DONE (DONE),
        .GNT  (GNT),
        .GID  (GID),
        .BUSY (BUSY),
        .TOUT (TOUT)
    );

    always #5 CK = ~CK;

    always @(posedge CK) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int want);
        total++;
        if (act != want) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (cycle %0d)", name, act, want, cyc);
        end
    endtask

    // drive inputs for the next edge and queue the outputs expected after it
    task automatic step(input logic [3:0] r, input logic d,
                        input logic [3:0] eg, input logic [1:0] eid, input logic et);
        exp_t e;
        REQ    = r;
        DONE   = d;
        e.cyc  = cyc + 1;
        e.gnt  = eg;
        e.gid  = eid;
        e.tout = et;
        q.push_back(e);
        @(posedge CK);
        #1;
    endtask

    always @(negedge CK) begin
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            me = q.pop_front();
            if (me.cyc != cyc) begin
                chk("late_entry", me.cyc, cyc);
            end else begin
                chk("gnt",  int'(GNT),  int'(me.gnt));
                chk("gid",  int'(GID),  int'(me.gid));
                chk("busy", int'(BUSY), int'(|me.gnt));
                chk("tout", int'(TOUT), int'(me.tout));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // reset state, applied without any clock edge
        #1 CDN = 1'b0;
        #1;
        chk("rst_gnt",  int'(GNT),  0);
        chk("rst_gid",  int'(GID),  0);
        chk("rst_busy", int'(BUSY), 0);
        chk("rst_tout", int'(TOUT), 0);
        repeat (2) @(posedge CK);
        #1 CDN = 1'b1;

        // full rotation with DONE one cycle after each grant
        step(4'b1111, 1'b0, 4'b0001, 2'd0, 1'b0);
        step(4'b1111, 1'b1, 4'b0000, 2'd0, 1'b0);
        step(4'b1111, 1'b0, 4'b0010, 2'd1, 1'b0);
        step(4'b1111, 1'b1, 4'b0000, 2'd1, 1'b0);
        step(4'b1111, 1'b0, 4'b0100, 2'd2, 1'b0);
        step(4'b1111, 1'b1, 4'b0000, 2'd2, 1'b0);
        step(4'b1111, 1'b0, 4'b1000, 2'd3, 1'b0);
        step(4'b1111, 1'b1, 4'b0000, 2'd3, 1'b0);
        step(4'b1111, 1'b0, 4'b0001, 2'd0, 1'b0);
        step(4'b1111, 1'b1, 4'b0000, 2'd0, 1'b0);

        // DONE in IDLE ignored; single request, hold, non-owner changes ignored
        step(4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0);
        step(4'b0100, 1'b0, 4'b0100, 2'd2, 1'b0);
        step(4'b0100, 1'b0, 4'b0100, 2'd2, 1'b0);
        step(4'b1111, 1'b0, 4'b0100, 2'd2, 1'b0);
        step(4'b0100, 1'b1, 4'b0000, 2'd2, 1'b0);

        // owner 1 drops its request; pointer then favours 2,3,0
        step(4'b0010, 1'b0, 4'b0010, 2'd1, 1'b0);
        step(4'b0000, 1'b0, 4'b0000, 2'd1, 1'b0);
        step(4'b0011, 1'b0, 4'b0001, 2'd0, 1'b0);
        step(4'b0011, 1'b1, 4'b0000, 2'd0, 1'b0);
        step(4'b0011, 1'b0, 4'b0010, 2'd1, 1'b0);
        step(4'b0011, 1'b1, 4'b0000, 2'd1, 1'b0);

        // async reset mid-grant
        step(4'b1000, 1'b0, 4'b1000, 2'd3, 1'b0);
        step(4'b1000, 1'b0, 4'b1000, 2'd3, 1'b0);
        #6;
        CDN = 1'b0;
        #1;
        chk("arst_gnt",  int'(GNT),  0);
        chk("arst_gid",  int'(GID),  0);
        chk("arst_busy", int'(BUSY), 0);
        @(posedge CK);
        #1 CDN = 1'b1;
        step(4'b1001, 1'b0, 4'b0001, 2'd0, 1'b0);
        step(4'b1001, 1'b1, 4'b0000, 2'd0, 1'b0);

        // long hold: forced release with the timeout, indefinite hold without
        step(4'b0010, 1'b0, 4'b0010, 2'd1, 1'b0);
`ifdef ARB4_TIMEOUT_EN
        repeat (14) step(4'b0010, 1'b0, 4'b0010, 2'd1, 1'b0);
        step(4'b0010, 1'b0, 4'b0000, 2'd1, 1'b1);
        step(4'b0010, 1'b0, 4'b0010, 2'd1, 1'b0);
`else
        repeat (110) step(4'b0010, 1'b0, 4'b0010, 2'd1, 1'b0);
`endif
        step(4'b0010, 1'b1, 4'b0000, 2'd1, 1'b0);

        for (int i = 0; i < 5 && q.size() > 0; i++) @(posedge CK);
        if (q.size() > 0) chk("drain", q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
